// File: rtl/sweep_pkg.sv
// Shared state encoding for the frequency-sweep scheduler.
// Types only; no logic, no latency, no flow control.
package sweep_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; load of 0 is taken as 1, expire is high while the count sits at 1.
// Load/decrement take effect at the next edge; no backpressure, the enable simply freezes the count.
module sweep_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? DWELL_W'(1) : load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep scheduler driving the phase counter's en/incr; all outputs come from registers, one-edge response to start/stop.
// No backpressure; optional pause input (SWEEP_PAUSE_EN) freezes the dwell count and drops cnt_en from the next edge.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               repeat_mode,
  input  logic [WIDTH-1:0]   incr_start,
  input  logic [WIDTH-1:0]   incr_end,
  input  logic [WIDTH-1:0]   incr_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               cnt_en,
  output logic [WIDTH-1:0]   cnt_incr,
  output logic               busy,
  output logic               step_tick,
  output logic               done
);

  sweep_state_t state_q, state_d;

  logic [WIDTH-1:0]   start_q, end_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               rep_q, dir_up_q;
  logic               paused, run_act, expire;
  logic               accept, step_end, reload;
  logic [WIDTH:0]     up_sum;
  logic [WIDTH-1:0]   down_gap, next_incr;

  assign run_act = (state_q == RUN) && !paused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    step_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (run_act && expire) begin
          step_end = 1'b1;
          if ((cnt_incr == end_q) && !rep_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step arithmetic saturates at the end value; the extra sum bit catches carry-out.
  always_comb begin
    up_sum   = {1'b0, cnt_incr} + {1'b0, step_q};
    down_gap = cnt_incr - end_q;
    if (cnt_incr == end_q)
      next_incr = start_q;
    else if (dir_up_q)
      next_incr = (up_sum > {1'b0, end_q}) ? end_q : up_sum[WIDTH-1:0];
    else
      next_incr = (down_gap < step_q) ? end_q : (cnt_incr - step_q);
  end

  assign reload = accept || (step_end && (state_d == RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_incr <= '0;
      start_q  <= '0;
      end_q    <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      rep_q    <= 1'b0;
      dir_up_q <= 1'b0;
    end else if (accept) begin
      cnt_incr <= incr_start;
      start_q  <= incr_start;
      end_q    <= incr_end;
      step_q   <= (incr_step == '0) ? WIDTH'(1) : incr_step;
      dwell_q  <= dwell;
      rep_q    <= repeat_mode;
      dir_up_q <= (incr_start <= incr_end);
    end else if (step_end && (state_d == RUN)) begin
      cnt_incr <= next_incr;
    end
  end

`ifdef SWEEP_PAUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paused <= 1'b0;
    else        paused <= pause && (state_d == RUN);
  end
`else
  assign paused = 1'b0;
`endif

  sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (reload),
    .load_val (accept ? dwell : dwell_q),
    .en       (run_act),
    .expire   (expire)
  );

  assign cnt_en    = run_act;
  assign busy      = (state_q == RUN);
  assign step_tick = run_act && expire;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a value-list model predicts every cnt_en/done cycle.
module tb_sweep_ctrl;

  localparam int WIDTH   = 8;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               repeat_mode = 1'b0;
  logic [WIDTH-1:0]   incr_start = '0;
  logic [WIDTH-1:0]   incr_end = '0;
  logic [WIDTH-1:0]   incr_step = '0;
  logic [DWELL_W-1:0] dwell = '0;
`ifdef SWEEP_PAUSE_EN
  logic               pause = 1'b0;
`endif
  logic               cnt_en, busy, step_tick, done;
  logic [WIDTH-1:0]   cnt_incr;

  typedef struct {
    int incr;
    bit tick;
    bit done_p;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_val = 0;

  always #5 clk = ~clk;

  sweep_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SWEEP_PAUSE_EN
    .pause       (pause),
`endif
    .start       (start),
    .stop        (stop),
    .repeat_mode (repeat_mode),
    .incr_start  (incr_start),
    .incr_end    (incr_end),
    .incr_step   (incr_step),
    .dwell       (dwell),
    .cnt_en      (cnt_en),
    .cnt_incr    (cnt_incr),
    .busy        (busy),
    .step_tick   (step_tick),
    .done        (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list the distinct values of the sweep, then expand each into dwell cycles.
  task automatic push_sweep(input int s, input int e, input int st, input int dw,
                            input bit rep, input int k);
    int stp = (st == 0) ? 1 : st;
    int d   = (dw == 0) ? 1 : dw;
    int x   = s;
    int v[$];
    exp_t r;
    v.push_back(x);
    while (x != e) begin
      if (s <= e) x = (x + stp > e) ? e : x + stp;
      else        x = (x - stp < e) ? e : x - stp;
      v.push_back(x);
    end
    if (!rep) begin
      foreach (v[i]) begin
        for (int c = 0; c < d; c++) begin
          r.incr = v[i]; r.tick = (c == d - 1); r.done_p = 1'b0;
          q.push_back(r);
        end
      end
      r.incr = e; r.tick = 1'b0; r.done_p = 1'b1;
      q.push_back(r);
      last_val = e;
    end else begin
      for (int n = 0; n < k; n++) begin
        r.incr = v[(n / d) % v.size()]; r.tick = ((n % d) == d - 1); r.done_p = 1'b0;
        q.push_back(r);
        last_val = r.incr;
      end
    end
  endtask

  // Called just after a posedge; returns just after the start edge with config scrambled.
  task automatic start_sweep(input int s, input int e, input int st, input int dw,
                             input bit rep, input int k);
    incr_start  = WIDTH'(s);
    incr_end    = WIDTH'(e);
    incr_step   = WIDTH'(st);
    dwell       = DWELL_W'(dw);
    repeat_mode = rep;
    push_sweep(s, e, st, dw, rep, k);
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    incr_start  = WIDTH'($urandom);
    incr_end    = WIDTH'($urandom);
    incr_step   = WIDTH'($urandom);
    dwell       = DWELL_W'($urandom_range(0, 5));
    repeat_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q.size() != 0 || busy || done) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_drain"}, q.size(), 0);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_hold"}, cnt_incr, last_val);
  endtask

  task automatic run_single(input string name, input int s, input int e, input int st, input int dw);
    start_sweep(s, e, st, dw, 1'b0, 0);
    wait_idle(name);
  endtask

  task automatic run_repeat(input string name, input int s, input int e, input int st,
                            input int dw, input int k);
    start_sweep(s, e, st, dw, 1'b1, k);
    repeat (k - 1) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk({name, "_stop_en"}, cnt_en, 0);
    chk({name, "_stop_busy"}, busy, 0);
    chk({name, "_stop_incr"}, cnt_incr, last_val);
    chk({name, "_stop_q"}, q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_stop_stay"}, busy, 0);
  endtask

  // Monitor: every cycle with cnt_en or done consumes one expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cnt_en || done) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: cnt_en=%0d done=%0d incr=%0d with nothing expected at %0t",
                     cnt_en, done, cnt_incr, $time);
          end else begin
            e = q.pop_front();
            chk("cnt_en", cnt_en, !e.done_p);
            chk("busy", busy, !e.done_p);
            chk("cnt_incr", cnt_incr, e.incr);
            chk("step_tick", step_tick, e.tick);
            chk("done", done, e.done_p);
          end
        end else if (step_tick) begin
          checks++;
          errors++;
          $display("FAIL stray_tick: step_tick=1 while cnt_en=0 at %0t", $time);
        end
      end
    end
  end

  initial begin
    int s, e, st, dw, k;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_incr", cnt_incr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Up sweep with an ignored start pulse mid-run.
    start_sweep(10, 40, 10, 3, 1'b0, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("up");

    run_single("clamp", 0, 25, 10, 1);
    run_single("nowrap", 250, 255, 10, 2);
    run_single("step0", 3, 6, 0, 1);
    run_single("down", 200, 180, 15, 2);
    run_single("down_clamp", 5, 0, 3, 1);
    run_single("dwell0", 1, 3, 1, 0);
    run_single("degenerate", 77, 77, 4, 2);
    run_repeat("repeat", 5, 7, 1, 1, 10);

    // start and stop together in IDLE: nothing may happen.
    incr_start = 8'd1; incr_end = 8'd9; incr_step = 8'd1; dwell = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("startstop_busy", busy, 0);
    chk("startstop_en", cnt_en, 0);

    // Asynchronous reset mid-sweep.
    start_sweep(20, 90, 5, 3, 1'b0, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_en", cnt_en, 0);
    chk("midrst_incr", cnt_incr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tick", step_tick, 0);
    chk("midrst_done", done, 0);
    q.delete();
    last_val = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
      dw = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 40);
        run_repeat("rnd_rep", s, e, st, dw, k);
      end else begin
        run_single("rnd", s, e, st, dw);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the enable and increment inputs of the signal generator's phase counter.
- Steps the increment from a start value to an end value in fixed-size steps, holding each value for a programmable dwell time.
- Runs the sweep once, or repeats it until stopped.
- Sits between the top-level control inputs and the counter. Its outputs drive the counter's en and incr ports directly.

Parameters:
WIDTH, 8, width of increment values; must match the counter's WIDTH
DWELL_W, 16, width of the dwell-cycle count

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a sweep; ignored unless idle
stop  in  1  abort the sweep; takes effect at the next edge
repeat_mode  in  1  0 = single sweep; 1 = wrap to start and continue
incr_start  in  WIDTH  first increment value
incr_end  in  WIDTH  final increment value
incr_step  in  WIDTH  step magnitude; 0 is treated as 1
dwell  in  DWELL_W  cycles per step; 0 is treated as 1
cnt_en  out  1  to counter en
cnt_incr  out  WIDTH  to counter incr
busy  out  1  high while a sweep is in progress
step_tick  out  1  one-cycle pulse on the last cycle of each step
done  out  1  one-cycle pulse when a single sweep completes

Behaviour:
- Reset (async assert, sync release): state IDLE; cnt_en=0, cnt_incr=0, busy=0, step_tick=0, done=0; internal registers cleared.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from the state register (no input-to-output combinational paths).
- Outputs by state:
  - cnt_en = (state==RUN); busy = (state==RUN).
  - done = 1 only in DONE.
- IDLE:
  - start=1 and stop=0 → latch incr_start, incr_end, incr_step, dwell, repeat_mode.
  - Direction: dir_up = (incr_start <= incr_end), fixed for the whole sweep.
  - Load cnt_incr=incr_start and dwell counter = max(dwell,1); go to RUN.
  - cnt_en rises the cycle after the start edge.
  - start and stop together → stay IDLE.
- Config inputs are sampled only at start; later changes have no effect until the next sweep.
- RUN:
  - Dwell counter decrements once per cycle; step_tick=1 when it reaches 1.
  - Each step therefore holds cnt_en=1 for exactly max(dwell,1) cycles.
- At step end, when cnt_incr != end:
  - Up: next = cnt_incr + step, computed in WIDTH+1 bits. If the sum > end or carries out, next = end.
  - Down: if cnt_incr - end < step, next = end; else next = cnt_incr - step.
  - No wrap-around ever occurs. The dwell counter reloads.
- At step end, when cnt_incr == end:
  - repeat_mode=1 → cnt_incr = latched start, dwell reloads, stay in RUN. done never asserts.
  - repeat_mode=0 → go to DONE.
- start during RUN is ignored.
- stop=1 in RUN → go to IDLE at the next edge. cnt_en=0 from then on; cnt_incr holds its last value; no done pulse; step_tick suppressed that cycle.
- DONE: lasts one cycle; cnt_en=0; cnt_incr holds end; next state IDLE. stop or start in DONE is ignored.
- Degenerate sweep start == end: one step of dwell cycles, then DONE.
- Reset mid-sweep: immediate return to reset values, regardless of state.
- Sweep length (single mode) = (number of distinct values) × max(dwell,1) cycles of cnt_en=1, followed by a 1-cycle done.

Optional Feature:
SWEEP_PAUSE_EN
- Defined: adds input port pause (1 bit). While pause=1 in RUN:
  - cnt_en=0, dwell counter frozen, step_tick=0, busy stays 1.
  - stop still takes priority.
  - Releasing pause resumes with the remaining dwell count.
- Not defined: port absent; behaviour exactly as above.

Decomposition:
- Package sweep_pkg: state enum typedef sweep_state_t {IDLE, RUN, DONE} and a localparam for the state encoding width.
- One natural sub-module, sweep_dwell_timer: loadable down-counter of width DWELL_W with load, enable and expire outputs.
- Step arithmetic and the FSM live in sweep_ctrl.

Test Plan:
- Up sweep: start=10, end=40, step=10, dwell=3, single → cnt_incr holds 10,20,30,40 for 3 cycles each (12 cycles of cnt_en=1), step_tick on cycles 3/6/9/12, done pulse on cycle 13, then IDLE.
- Clamp: start=0, end=25, step=10, dwell=1 → 0,10,20,25. Boundary case start=250, end=255, step=10 → 250,255 with no wrap. step=0 behaves as step=1.
- Down sweep: start=200, end=180, step=15, dwell=2 → 200,185,180, then done.
- Repeat: start=5, end=7, step=1, dwell=1, repeat_mode=1 → 5,6,7,5,6,7,… with done never asserted. stop asserted mid-sweep → cnt_en=0 and busy=0 next cycle, cnt_incr frozen.
- Reset and simultaneous events: rst_n low mid-RUN → all outputs 0 asynchronously. start+stop together in IDLE → no sweep. start during RUN → ignored. dwell=0 behaves as dwell=1.
- SWEEP_PAUSE_EN: dwell=4, pause high for 5 cycles after 2 dwell cycles → cnt_en=0 and busy=1 during the pause, then 2 remaining cycles before the next step.
